// File: rtl/nx_xrfb_fifo_ctrl.sv
// FIFO controller that uses an external NX_XRFB register file as storage.
// The output stage is a registered first-word-fall-through stage fed from the RF read port.
module nx_xrfb_fifo_ctrl #(
  parameter int WIDTH = 18,
  parameter int AW    = 6
) (
  input  logic             CK,
  input  logic             R,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic [AW:0]      LEVEL,
  output logic [AW-1:0]    RF_WA,
  output logic             RF_WE,
  output logic [WIDTH-1:0] RF_I,
  output logic [AW-1:0]    RF_RA,
  input  logic [WIDTH-1:0] RF_O
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Only the two geometries the XRFB primitive supports are legal.
  generate
    if (!((WIDTH == 18 && AW == 6) || (WIDTH == 36 && AW == 5))) begin : g_bad_cfg
      $error("nx_xrfb_fifo_ctrl: WIDTH/AW must be 18/6 or 36/5");
    end
  endgenerate

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      rf_cnt_reg;
  logic [AW:0]      rf_cnt_next;
  logic             m_valid_reg;
  logic [WIDTH-1:0] m_data_reg;
  logic             push;
  logic             load;

  // Readiness uses the registered count only, so a full RF never falls through on a load.
  always_comb begin
    S_READY     = !R && (rf_cnt_reg != FULL_CNT);
    push        = S_VALID && S_READY;
    load        = (rf_cnt_reg != '0) && (!m_valid_reg || M_READY);
    rf_cnt_next = rf_cnt_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
  end

  assign RF_WE   = push;
  assign RF_WA   = wr_ptr_reg;
  assign RF_I    = S_DATA;
  assign RF_RA   = rd_ptr_reg;
  assign M_VALID = m_valid_reg;
  assign M_DATA  = m_data_reg;
  assign LEVEL   = rf_cnt_reg + {{AW{1'b0}}, m_valid_reg};

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rf_cnt_reg  <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      // A load refills the output register; otherwise a taken word just empties it.
      if (load) begin
        m_data_reg  <= RF_O;
        m_valid_reg <= 1'b1;
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
      end else if (m_valid_reg && M_READY) begin
        m_valid_reg <= 1'b0;
      end
      rf_cnt_reg <= rf_cnt_next;
    end
  end

endmodule

// File: tb/tb_nx_xrfb_fifo_ctrl.sv
// Bench for nx_xrfb_fifo_ctrl: two instances (18x64 and 36x32) each with a behavioural RF,
// directed stimulus and per-instance scoreboard monitors.
module tb_nx_xrfb_fifo_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r;
  int   checks   = 0;
  int   failures = 0;

  // Instance A: WIDTH=18, AW=6
  logic        s_valid_a, s_ready_a, m_valid_a, m_ready_a, rf_we_a;
  logic [17:0] s_data_a, m_data_a, rf_i_a, rf_o_a;
  logic [6:0]  level_a;
  logic [5:0]  rf_wa_a, rf_ra_a;
  logic [17:0] rf_a [64];
  logic [17:0] exp_a [$];
  logic [17:0] e_a;

  // Instance B: WIDTH=36, AW=5
  logic        s_valid_b, s_ready_b, m_valid_b, m_ready_b, rf_we_b;
  logic [35:0] s_data_b, m_data_b, rf_i_b, rf_o_b;
  logic [5:0]  level_b;
  logic [4:0]  rf_wa_b, rf_ra_b;
  logic [35:0] rf_b [32];
  logic [35:0] exp_b [$];
  logic [35:0] e_b;

  int sent;
  int nb;
  bit saw_wrap;

  nx_xrfb_fifo_ctrl #(.WIDTH(18), .AW(6)) dut_a (
    .CK(clk), .R(r),
    .S_VALID(s_valid_a), .S_READY(s_ready_a), .S_DATA(s_data_a),
    .M_VALID(m_valid_a), .M_READY(m_ready_a), .M_DATA(m_data_a),
    .LEVEL(level_a),
    .RF_WA(rf_wa_a), .RF_WE(rf_we_a), .RF_I(rf_i_a), .RF_RA(rf_ra_a), .RF_O(rf_o_a)
  );

  nx_xrfb_fifo_ctrl #(.WIDTH(36), .AW(5)) dut_b (
    .CK(clk), .R(r),
    .S_VALID(s_valid_b), .S_READY(s_ready_b), .S_DATA(s_data_b),
    .M_VALID(m_valid_b), .M_READY(m_ready_b), .M_DATA(m_data_b),
    .LEVEL(level_b),
    .RF_WA(rf_wa_b), .RF_WE(rf_we_b), .RF_I(rf_i_b), .RF_RA(rf_ra_b), .RF_O(rf_o_b)
  );

  // Behavioural register files: synchronous write, combinational read.
  always @(posedge clk) begin
    if (rf_we_a) rf_a[rf_wa_a] <= rf_i_a;
    if (rf_we_b) rf_b[rf_wa_b] <= rf_i_b;
  end
  assign rf_o_a = rf_a[rf_ra_a];
  assign rf_o_b = rf_b[rf_ra_b];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitors: a word handed over at the coming edge must match the queue head.
  always @(negedge clk) begin
    if (!r && m_valid_a && m_ready_a) begin
      if (exp_a.size() == 0) begin
        chk("a_pop_unexpected", {46'd0, m_data_a}, 64'hDEAD);
      end else begin
        e_a = exp_a.pop_front();
        $display("pop a data=%05h expected=%05h", m_data_a, e_a);
        chk("a_pop_data", {46'd0, m_data_a}, {46'd0, e_a});
      end
    end
  end

  always @(negedge clk) begin
    if (!r && m_valid_b && m_ready_b) begin
      if (exp_b.size() == 0) begin
        chk("b_pop_unexpected", {28'd0, m_data_b}, 64'hDEAD);
      end else begin
        e_b = exp_b.pop_front();
        $display("pop b data=%09h expected=%09h", m_data_b, e_b);
        chk("b_pop_data", {28'd0, m_data_b}, {28'd0, e_b});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    r = 1'b1;
    s_valid_a = 1'b1; s_data_a = 18'h3FFFF; m_ready_a = 1'b0;
    s_valid_b = 1'b0; s_data_b = '0;        m_ready_b = 1'b0;

    // Reset held three cycles with S_VALID high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_rf_we",   rf_we_a,   0);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_level",   level_a,   0);
    chk("rst_m_data",  m_data_a,  0);
    @(posedge clk); #1 r = 1'b0;
    #1 chk("rel_s_ready", s_ready_a, 1);
    s_valid_a = 1'b0;

    // Single word
    @(posedge clk); #1 s_valid_a = 1'b1; s_data_a = 18'h2A5F5;
    @(negedge clk);
    chk("sw_rf_we", rf_we_a, 1);
    chk("sw_rf_wa", rf_wa_a, 0);
    chk("sw_rf_i",  rf_i_a,  18'h2A5F5);
    if (s_ready_a) exp_a.push_back(18'h2A5F5);
    @(posedge clk); #1 s_valid_a = 1'b0;
    @(negedge clk);
    chk("sw_mvalid_e0", m_valid_a, 0);
    chk("sw_level_e0",  level_a,   1);
    @(negedge clk);
    chk("sw_mvalid_e1", m_valid_a, 1);
    chk("sw_mdata_e1",  m_data_a,  18'h2A5F5);
    chk("sw_level_e1",  level_a,   1);
    @(posedge clk); #1 m_ready_a = 1'b1;
    @(posedge clk); #1 m_ready_a = 1'b0;
    @(negedge clk);
    chk("sw_level_end",  level_a,   0);
    chk("sw_mvalid_end", m_valid_a, 0);

    // Fill with the consumer stalled: 65 words fit
    for (int i = 0; i < 65; i++) begin
      @(posedge clk); #1 s_valid_a = 1'b1; s_data_a = 18'(i);
      @(negedge clk);
      chk("fill_s_ready", s_ready_a, 1);
      if (s_ready_a) exp_a.push_back(18'(i));
    end
    @(posedge clk); #1 s_data_a = 18'h00100;
    @(negedge clk);
    chk("full_s_ready", s_ready_a, 0);
    chk("full_level",   level_a,   65);

    // Full with a concurrent pop: no push that cycle
    @(posedge clk); #1 m_ready_a = 1'b1;
    @(negedge clk);
    chk("fp_s_ready", s_ready_a, 0);
    @(posedge clk); #1 m_ready_a = 1'b0;
    @(negedge clk);
    chk("fp_level",        level_a,   64);
    chk("fp_s_ready_next", s_ready_a, 1);
    if (s_ready_a) exp_a.push_back(18'h00100);
    @(posedge clk); #1 s_valid_a = 1'b0;
    @(negedge clk);
    chk("fp_level_refill", level_a, 65);

    // Drain the remaining 65 words without gaps
    @(posedge clk); #1 m_ready_a = 1'b1;
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      chk("drain_gap", m_valid_a, 1);
    end
    @(posedge clk); #1 m_ready_a = 1'b0;
    @(negedge clk);
    chk("drain_level", level_a, 0);
    chk("drain_left",  exp_a.size(), 0);

    // Random stream of 200 words across the pointer wrap
    sent = 0; saw_wrap = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (sent == 200 && exp_a.size() == 0) break;
      s_valid_a = (sent < 200) && ($urandom_range(0, 3) != 0);
      s_data_a  = 18'h20000 + 18'(sent);
      m_ready_a = (sent >= 200) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (s_valid_a && s_ready_a) begin
        if (rf_wa_a == 6'd63) saw_wrap = 1'b1;
        exp_a.push_back(s_data_a);
        sent++;
      end
    end
    s_valid_a = 1'b0; m_ready_a = 1'b0;
    chk("wrap_sent", sent, 200);
    chk("wrap_left", exp_a.size(), 0);
    chk("wrap_seen", saw_wrap, 1);

    // Reset in the middle of operation at LEVEL=30
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1 s_valid_a = 1'b1; s_data_a = 18'h30000 + 18'(i);
      @(negedge clk);
      if (s_ready_a) exp_a.push_back(s_data_a);
    end
    @(posedge clk); #1 s_valid_a = 1'b0;
    @(negedge clk);
    chk("mr_level30", level_a, 30);
    #1 r = 1'b1;
    #1;
    chk("mr_level0",  level_a,   0);
    chk("mr_mvalid0", m_valid_a, 0);
    exp_a.delete();
    @(posedge clk); #1 r = 1'b0;
    @(posedge clk); #1 s_valid_a = 1'b1; s_data_a = 18'h00011; m_ready_a = 1'b1;
    @(negedge clk);
    chk("mr_post_ready", s_ready_a, 1);
    if (s_ready_a) exp_a.push_back(18'h00011);
    @(posedge clk); #1 s_valid_a = 1'b0;
    for (int i = 0; i < 10 && exp_a.size() != 0; i++) @(posedge clk);
    #1;
    chk("mr_first_out", exp_a.size(), 0);
    @(negedge clk);
    chk("mr_level_end",  level_a,   0);
    chk("mr_mvalid_end", m_valid_a, 0);
    m_ready_a = 1'b0;

    // 36x32 variant: capacity 33, then a random stream past the wrap
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1 s_valid_b = 1'b1; s_data_b = 36'hA00000000 + 36'(nb);
      @(negedge clk);
      if (!s_ready_b) break;
      exp_b.push_back(s_data_b);
      nb++;
    end
    chk("b_capacity", nb, 33);
    chk("b_level",    level_b, 33);
    @(posedge clk); #1 s_valid_b = 1'b0;
    sent = 0; saw_wrap = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (sent == 100 && exp_b.size() == 0) break;
      s_valid_b = (sent < 100) && ($urandom_range(0, 3) != 0);
      s_data_b  = 36'hB00000000 + 36'(sent);
      m_ready_b = (sent >= 100) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (s_valid_b && s_ready_b) begin
        if (rf_wa_b == 5'd31) saw_wrap = 1'b1;
        exp_b.push_back(s_data_b);
        sent++;
      end
    end
    s_valid_b = 1'b0; m_ready_b = 1'b0;
    chk("b_sent",      sent, 100);
    chk("b_left",      exp_b.size(), 0);
    chk("b_wrap_seen", saw_wrap, 1);
    @(negedge clk);
    chk("b_level_end", level_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nx_xrfb_fifo_ctrl.md
Name: nx_xrfb_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives one NX_XRFB register-file primitive (64x18 or 32x36) as its storage.
- Upstream: feeds the RF write port (WA/WE/I) from a valid/ready producer stream.
- Downstream: consumes the RF asynchronous read output (O) into a registered, first-word-fall-through output stage for a valid/ready consumer.
- Used wherever a small FIFO is inferred onto XRFB instead of LUT/DFF fabric.

Parameters:
- WIDTH, 18, data width; legal values 18 and 36 only.
- AW, 6, RF address width; must be 6 when WIDTH=18 and 5 when WIDTH=36. Any other pair is an elaboration error.
- DEPTH, 2**AW (derived localparam), RF entries.

Ports:
- CK  in  1  clock, rising edge; same net as RF WCK, with RF wck_edge=0.
- R  in  1  asynchronous active-high reset.
- S_VALID  in  1  producer has data.
- S_READY  out  1  FIFO can accept.
- S_DATA  in  WIDTH  producer data.
- M_VALID  out  1  M_DATA holds a valid word.
- M_READY  in  1  consumer takes word.
- M_DATA  out  WIDTH  registered output word.
- LEVEL  out  AW+1  words held (RF plus output register), range 0..DEPTH+1.
- RF_WA  out  AW  RF write address.
- RF_WE  out  1  RF write enable (RF WEA tied 1).
- RF_I  out  WIDTH  RF write data.
- RF_RA  out  AW  RF read address.
- RF_O  in  WIDTH  RF combinational read data.

Behaviour:
- State:
  - wr_ptr, rd_ptr: AW bits each, wrap modulo DEPTH.
  - rf_cnt: AW+1 bits, 0..DEPTH.
  - M_VALID, M_DATA: registers.
- Reset (R high, async): wr_ptr=0, rd_ptr=0, rf_cnt=0, M_VALID=0, M_DATA=0. LEVEL=0. S_READY=0 while R is high.
- Push:
  - S_READY = !R && (rf_cnt != DEPTH).
  - push = S_VALID && S_READY.
  - Combinationally: RF_WE=push, RF_WA=wr_ptr, RF_I=S_DATA.
  - On the CK edge with push: wr_ptr+1.
- Load:
  - RF_RA = rd_ptr at all times.
  - load = (rf_cnt != 0) && (!M_VALID || M_READY).
  - On the CK edge with load: M_DATA<=RF_O, M_VALID<=1, rd_ptr+1.
- Pop: if M_VALID && M_READY && !load, M_VALID<=0. M_DATA holds its last value.
- rf_cnt next = rf_cnt + push - load. Both may occur in the same cycle, giving net 0.
- LEVEL = rf_cnt + M_VALID, combinational from registers.
- Latency:
  - A word pushed at edge k is in the RF after edge k.
  - It can be loaded at edge k+1, so M_VALID is high after edge k+1 (2 cycles from S_VALID&S_READY sampled to M_VALID).
  - There is no bypass path from S_DATA to M_DATA.
- Hazards:
  - No same-address read/write can occur. load needs rf_cnt != 0, so rd_ptr never points at the slot written this cycle when it matters.
  - The RF read-during-write result is never used.
- Full:
  - rf_cnt == DEPTH forces S_READY=0, even if a load happens that cycle (registered-count rule, no fall-through).
  - Total capacity is DEPTH+1.
- Empty: rf_cnt == 0 means no load; M_VALID stays at its current value until popped.
- Backpressure: while M_VALID && !M_READY, M_DATA and rd_ptr are stable.
- Reset mid-operation: all contents are discarded immediately. RF contents are not cleared but are unreachable.
- Outputs are free of X after reset. RF INIT content is never presented.

Test Plan:
- Reset: assert R for 3 cycles with S_VALID=1 -> S_READY=0, RF_WE=0, M_VALID=0, LEVEL=0. After release, S_READY=1 on the first cycle.
- Single word: push 18'h2A5F5 at edge 0 with M_READY=0 -> RF_WE=1 and RF_WA=0 in that cycle; M_VALID=1 and M_DATA=18'h2A5F5 after edge 1; LEVEL=1.
- Fill: M_READY=0, push 0..64 -> 65 words accepted, S_READY drops after the 65th push, LEVEL=65. Then M_READY=1 drains 0..64 in order with no gaps.
- Full with concurrent pop: at LEVEL=65, drive S_VALID=1 and M_READY=1 -> no push that cycle, one pop, LEVEL=64. Next cycle S_READY=1 and the push is accepted.
- Wrap: stream 200 incrementing words with random S_VALID/M_READY -> output equals input order; pointers wrap past 63 to 0; no word is lost or duplicated.
- Mid-operation reset at LEVEL=30 -> LEVEL=0 and M_VALID=0 immediately. The next pushed word 18'h00011 is the first word out.
- WIDTH=36, AW=5 variant: capacity 33, wrap past 31, same data-order check.
